// File: rtl/multicycle_main_ctrl_if.sv
// Opcode/handshake inputs and datapath control strobes of the multicycle MIPS main control.
// Optional macro MC_CTRL_BNE_EN adds the pc_write_ncond strobe.
interface multicycle_main_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic       bus_error;
`ifdef MC_CTRL_BNE_EN
  logic       pc_write_ncond;
`endif

  // Controller side: consumes opcode/ready, drives strobes
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    output mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
    output pc_source, illegal_op, bus_error
`ifdef MC_CTRL_BNE_EN
    , output pc_write_ncond
`endif
  );

  // Datapath side: supplies opcode/ready, consumes strobes
  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    input  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
    input  pc_source, illegal_op, bus_error
`ifdef MC_CTRL_BNE_EN
    , input pc_write_ncond
`endif
  );
endinterface

// File: rtl/multicycle_main_ctrl.sv
// Main control FSM for the multicycle MIPS datapath. Strobes are registered from the
// next state; only the FETCH ir_write/pc_write are qualified by mem_ready in the same cycle.
// Optional macro MC_CTRL_BNE_EN adds the BNEQ state and the pc_write_ncond strobe.
module multicycle_main_ctrl #(
  parameter int unsigned WAIT_MAX = 255,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_main_ctrl_if.master  ctrl
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPE,
    S_RWB, S_BRANCH, S_JUMP, S_ADDI, S_ORI, S_IWB, S_ERR, S_BNEQ
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;
  logic              ncond_q, ncond_d;
  logic              mem_state_c;
  logic              fetch_rdy_c;

  // State, wait counter, strobes and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST;
      wait_q    <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      ncond_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      ncond_q   <= ncond_d;
    end
  end

  // Next state, memory-wait timeout and sticky error capture
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    illegal_d   = illegal_q;
    bus_err_d   = bus_err_q;
    mem_state_c = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  if (ctrl.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (ctrl.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI;
          OP_ORI:       state_d = S_ORI;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_d = S_BNEQ;
`endif
          default: begin
            state_d   = S_ERR;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (ctrl.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (ctrl.mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (ctrl.mem_ready) state_d = S_FETCH;
      S_RTYPE:  state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDI:   state_d = S_IWB;
      S_ORI:    state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_ERR:    state_d = S_ERR;
`ifdef MC_CTRL_BNE_EN
      S_BNEQ:   state_d = S_FETCH;
`else
      S_BNEQ:   state_d = S_ERR;
`endif
      default:  state_d = S_ERR;
    endcase

    // A ready on the final allowed cycle still completes normally
    if (mem_state_c) begin
      if (ctrl.mem_ready) begin
        wait_d = '0;
      end else if (wait_q == WAIT_W'(WAIT_MAX - 1)) begin
        state_d   = S_ERR;
        bus_err_d = 1'b1;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end

    if ((state_d != state_q) &&
        ((state_d == S_FETCH) || (state_d == S_MEMRD) || (state_d == S_MEMWR))) begin
      wait_d = '0;
    end
  end

  // Strobe decode of the state being entered; IWB keeps the ALU selects of ADDI/ORI
  always_comb begin
    ctrl_d  = '0;
    ncond_d = 1'b0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.alu_src_b = 2'b01;
      end
      S_DECODE: ctrl_d.alu_src_b = 2'b11;
      S_MEMADR: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.i_or_d    = 1'b1;
      end
      S_RTYPE: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_op    = 2'b10;
      end
      S_RWB: begin
        ctrl_d.reg_dst   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = 2'b10;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_op        = 2'b01;
        ctrl_d.pc_write_cond = 1'b1;
        ctrl_d.pc_source     = 2'b01;
      end
      S_JUMP: begin
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.pc_source = 2'b10;
      end
      S_ADDI: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
      end
      S_ORI: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
        ctrl_d.alu_op    = 2'b11;
      end
      S_IWB: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src_a = ctrl_q.alu_src_a;
        ctrl_d.alu_src_b = ctrl_q.alu_src_b;
        ctrl_d.alu_op    = ctrl_q.alu_op;
      end
`ifdef MC_CTRL_BNE_EN
      S_BNEQ: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_op    = 2'b01;
        ctrl_d.pc_source = 2'b01;
        ncond_d          = 1'b1;
      end
`endif
      default: ctrl_d = '0;
    endcase
  end

  // FETCH only latches IR / advances PC in the cycle memory delivers
  assign fetch_rdy_c = (state_q == S_FETCH) && ctrl.mem_ready;

  assign ctrl.pc_write      = ctrl_q.pc_write | fetch_rdy_c;
  assign ctrl.ir_write      = fetch_rdy_c;
  assign ctrl.pc_write_cond = ctrl_q.pc_write_cond;
  assign ctrl.i_or_d        = ctrl_q.i_or_d;
  assign ctrl.mem_read      = ctrl_q.mem_read;
  assign ctrl.mem_write     = ctrl_q.mem_write;
  assign ctrl.mem_to_reg    = ctrl_q.mem_to_reg;
  assign ctrl.reg_dst       = ctrl_q.reg_dst;
  assign ctrl.reg_write     = ctrl_q.reg_write;
  assign ctrl.alu_src_a     = ctrl_q.alu_src_a;
  assign ctrl.alu_src_b     = ctrl_q.alu_src_b;
  assign ctrl.alu_op        = ctrl_q.alu_op;
  assign ctrl.pc_source     = ctrl_q.pc_source;
  assign ctrl.illegal_op    = illegal_q;
  assign ctrl.bus_error     = bus_err_q;
`ifdef MC_CTRL_BNE_EN
  assign ctrl.pc_write_ncond = ncond_q;
`else
  logic unused_ncond;
  assign unused_ncond = ncond_q;
`endif

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Directed bench for multicycle_main_ctrl: per-cycle expected strobe vectors are queued
// as stimulus is driven and popped when the outputs are sampled mid-cycle.
module tb_multicycle_main_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  localparam int T_RST = 0,  T_FETCH = 1,  T_DECODE = 2,  T_MEMADR = 3, T_MEMRD = 4;
  localparam int T_MEMWB = 5, T_MEMWR = 6, T_RTYPE = 7,   T_RWB = 8,    T_BRANCH = 9;
  localparam int T_JUMP = 10, T_ADDI = 11, T_ORI = 12,    T_IWB_ADDI = 13, T_IWB_ORI = 14;
  localparam int T_ERR_ILL = 15, T_ERR_BUS = 16, T_BNEQ = 17;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       bus_error;
    logic       pc_write_ncond;
  } obs_t;

  logic clk;
  logic rst_n;
  multicycle_main_ctrl_if bus ();

  multicycle_main_ctrl #(.WAIT_MAX(255), .WAIT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ctrl (bus.master)
  );

  int   checks = 0;
  int   errors = 0;
  obs_t sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs per state, written straight from the state table
  function automatic obs_t exp_of(input int st, input logic rdy);
    obs_t e;
    e = '0;
    case (st)
      T_FETCH:    begin e.mem_read = 1; e.ir_write = rdy; e.pc_write = rdy; e.alu_src_b = 2'b01; end
      T_DECODE:   e.alu_src_b = 2'b11;
      T_MEMADR:   begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      T_MEMRD:    begin e.mem_read = 1; e.i_or_d = 1; end
      T_MEMWB:    begin e.reg_write = 1; e.mem_to_reg = 1; end
      T_MEMWR:    begin e.mem_write = 1; e.i_or_d = 1; end
      T_RTYPE:    begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      T_RWB:      begin e.reg_dst = 1; e.reg_write = 1; e.alu_op = 2'b10; end
      T_BRANCH:   begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_source = 2'b01; end
      T_JUMP:     begin e.pc_write = 1; e.pc_source = 2'b10; end
      T_ADDI:     begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      T_ORI:      begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b11; end
      T_IWB_ADDI: begin e.reg_write = 1; e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      T_IWB_ORI:  begin e.reg_write = 1; e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b11; end
      T_ERR_ILL:  e.illegal_op = 1;
      T_ERR_BUS:  e.bus_error = 1;
      T_BNEQ:     begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_source = 2'b01; e.pc_write_ncond = 1; end
      default:    e = '0;
    endcase
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pc_write      = bus.pc_write;
    o.pc_write_cond = bus.pc_write_cond;
    o.i_or_d        = bus.i_or_d;
    o.mem_read      = bus.mem_read;
    o.mem_write     = bus.mem_write;
    o.ir_write      = bus.ir_write;
    o.mem_to_reg    = bus.mem_to_reg;
    o.reg_dst       = bus.reg_dst;
    o.reg_write     = bus.reg_write;
    o.alu_src_a     = bus.alu_src_a;
    o.alu_src_b     = bus.alu_src_b;
    o.alu_op        = bus.alu_op;
    o.pc_source     = bus.pc_source;
    o.illegal_op    = bus.illegal_op;
    o.bus_error     = bus.bus_error;
`ifdef MC_CTRL_BNE_EN
    o.pc_write_ncond = bus.pc_write_ncond;
`else
    o.pc_write_ncond = 1'b0;
`endif
    return o;
  endfunction

  task automatic check(input string name);
    obs_t exp_v;
    obs_t obs_v;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      exp_v = sb_q.pop_front();
      obs_v = sample();
      checks++;
      assert (obs_v === exp_v) else begin
        errors++;
        $error("FAIL %s: observed %05h expected %05h", name, obs_v, exp_v);
      end
    end
  endtask

  // One clock: drive inputs on the falling edge, then check the current state's outputs
  task automatic cyc(input int st, input logic [5:0] op, input logic rdy, input string name);
    @(negedge clk);
    bus.opcode    = op;
    bus.mem_ready = rdy;
    sb_q.push_back(exp_of(st, rdy));
    #1;
    check(name);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode    = OP_RTYPE;
    repeat (3) @(negedge clk);
    sb_q.push_back(exp_of(T_RST, 1'b1));
    #1;
    check("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(exp_of(T_RST, 1'b1));
    #1;
    check("reset_cycle0");
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.opcode    = OP_RTYPE;
    bus.mem_ready = 1'b1;
    do_reset();

    // lw: five states
    cyc(T_FETCH,  OP_LW, 1, "lw_fetch");
    cyc(T_DECODE, OP_LW, 1, "lw_decode");
    cyc(T_MEMADR, OP_LW, 1, "lw_memadr");
    cyc(T_MEMRD,  OP_LW, 1, "lw_memrd");
    cyc(T_MEMWB,  OP_LW, 1, "lw_memwb");

    // R-type with a 3-cycle fetch stall (ir_write/pc_write held off)
    cyc(T_FETCH,  OP_RTYPE, 0, "r_fetch_stall");
    cyc(T_FETCH,  OP_RTYPE, 0, "r_fetch_stall");
    cyc(T_FETCH,  OP_RTYPE, 0, "r_fetch_stall");
    cyc(T_FETCH,  OP_RTYPE, 1, "r_fetch");
    cyc(T_DECODE, OP_RTYPE, 1, "r_decode");
    cyc(T_RTYPE,  OP_RTYPE, 1, "r_exec");
    cyc(T_RWB,    OP_RTYPE, 1, "r_wb");

    // ori and addi: IWB keeps the immediate ALU selects
    cyc(T_FETCH,    OP_ORI, 1, "ori_fetch");
    cyc(T_DECODE,   OP_ORI, 1, "ori_decode");
    cyc(T_ORI,      OP_ORI, 1, "ori_exec");
    cyc(T_IWB_ORI,  OP_ORI, 1, "ori_wb");
    cyc(T_FETCH,    OP_ADDI, 1, "addi_fetch");
    cyc(T_DECODE,   OP_ADDI, 1, "addi_decode");
    cyc(T_ADDI,     OP_ADDI, 1, "addi_exec");
    cyc(T_IWB_ADDI, OP_ADDI, 1, "addi_wb");

    // beq and j
    cyc(T_FETCH,  OP_BEQ, 1, "beq_fetch");
    cyc(T_DECODE, OP_BEQ, 1, "beq_decode");
    cyc(T_BRANCH, OP_BEQ, 1, "beq_branch");
    cyc(T_FETCH,  OP_J,   1, "j_fetch");
    cyc(T_DECODE, OP_J,   1, "j_decode");
    cyc(T_JUMP,   OP_J,   1, "j_jump");

    // sw with ready low 3 cycles: mem_write held 4 cycles
    cyc(T_FETCH,  OP_SW, 1, "sw_fetch");
    cyc(T_DECODE, OP_SW, 1, "sw_decode");
    cyc(T_MEMADR, OP_SW, 1, "sw_memadr");
    cyc(T_MEMWR,  OP_SW, 0, "sw_stall");
    cyc(T_MEMWR,  OP_SW, 0, "sw_stall");
    cyc(T_MEMWR,  OP_SW, 0, "sw_stall");
    cyc(T_MEMWR,  OP_SW, 1, "sw_memwr_done");

    // lw with ready arriving on the last allowed cycle: no bus error
    cyc(T_FETCH,  OP_LW, 0, "lwb_fetch_stall");
    cyc(T_FETCH,  OP_LW, 1, "lwb_fetch");
    cyc(T_DECODE, OP_LW, 1, "lwb_decode");
    cyc(T_MEMADR, OP_LW, 1, "lwb_memadr");
    for (int i = 0; i < 254; i++) cyc(T_MEMRD, OP_LW, 0, "lwb_stall");
    cyc(T_MEMRD,  OP_LW, 1, "lwb_ready_last");
    cyc(T_MEMWB,  OP_LW, 1, "lwb_memwb");

    // Illegal opcode: sticky illegal_op in ERR
    cyc(T_FETCH,   OP_BAD, 1, "ill_fetch");
    cyc(T_DECODE,  OP_BAD, 1, "ill_decode");
    cyc(T_ERR_ILL, OP_LW,  1, "ill_err");
    cyc(T_ERR_ILL, OP_LW,  0, "ill_err_sticky");
    cyc(T_ERR_ILL, OP_SW,  1, "ill_err_sticky");

    // sw timeout: 255 stalled cycles in MEMWR -> ERR with bus_error
    do_reset();
    cyc(T_FETCH,  OP_SW, 1, "to_fetch");
    cyc(T_DECODE, OP_SW, 1, "to_decode");
    cyc(T_MEMADR, OP_SW, 1, "to_memadr");
    for (int i = 0; i < 255; i++) cyc(T_MEMWR, OP_SW, 0, "to_stall");
    cyc(T_ERR_BUS, OP_SW, 1, "to_err");
    cyc(T_ERR_BUS, OP_LW, 1, "to_err_sticky");

    // Mid-instruction reset abandons the instruction at once
    do_reset();
    cyc(T_FETCH,  OP_LW, 1, "mid_fetch");
    cyc(T_DECODE, OP_LW, 1, "mid_decode");
    cyc(T_MEMADR, OP_LW, 1, "mid_memadr");
    rst_n = 1'b0;
    sb_q.push_back(exp_of(T_RST, 1'b1));
    #1;
    check("mid_reset_async");
    do_reset();

    // Opcode 000101: BNEQ when enabled, otherwise illegal
    cyc(T_FETCH,  OP_BNE, 1, "bne_fetch");
    cyc(T_DECODE, OP_BNE, 1, "bne_decode");
`ifdef MC_CTRL_BNE_EN
    cyc(T_BNEQ,   OP_BNE, 1, "bne_exec");
    cyc(T_FETCH,  OP_LW,  1, "bne_next_fetch");
`else
    cyc(T_ERR_ILL, OP_BNE, 1, "bne_illegal");
    cyc(T_ERR_ILL, OP_LW,  1, "bne_illegal_sticky");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
